// File: rtl/spi_mem_pkg.sv
// Shared encodings for the serial-SRAM slave model: opcodes, mode field values, FSM states.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;
  localparam logic [7:0] CMD_WRMR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_RD,
    ST_WR,
    ST_MODE_RD,
    ST_MODE_WR,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus single-cycle edge pulses on the synced SPI clock.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sck_i,
  input  logic ce_n_i,
  input  logic mosi_i,
  output logic ce_n_o,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o
);

  logic [1:0] sck_q, ce_q, mosi_q;
  logic       sck_prev_q;

  // CE resets low on purpose: the top only arms after it sees CE high, so a
  // transaction interrupted by reset is never resumed mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q      <= 2'b00;
      ce_q       <= 2'b00;
      mosi_q     <= 2'b00;
      sck_prev_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[0], sck_i};
      ce_q       <= {ce_q[0], ce_n_i};
      mosi_q     <= {mosi_q[0], mosi_i};
      sck_prev_q <= sck_q[1];
    end
  end

  assign ce_n_o     = ce_q[1];
  assign mosi_o     = mosi_q[1];
  assign sck_rise_o = sck_q[1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_q[1] & sck_prev_q;

endmodule

// File: rtl/spi_sram_model.sv
// 23LC-style serial SRAM slave (SPI mode 0) oversampled by the system clock, with backdoor preload.
module spi_sram_model
  import spi_mem_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int ADDR_BYTES = 3,
  parameter int PAGE_SIZE  = 32,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_clk,
  input  logic          spi_ce,
  input  logic          spi_mosi,
  output logic          spi_miso,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  output logic          busy,
  output logic [2:0]    dbg_state_o
);

  localparam int ADDR_W = 8 * ADDR_BYTES;
  localparam int CW     = $clog2(ADDR_W);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);

  logic ce_s, mosi_s, sck_rise, sck_fall;

  spi_pin_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck_i      (spi_clk),
    .ce_n_i     (spi_ce),
    .mosi_i     (spi_mosi),
    .ce_n_o     (ce_s),
    .mosi_o     (mosi_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall)
  );

  state_e              state_q, state_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   in_sh_q, in_sh_d;
  logic [7:0]          out_sh_q, out_sh_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [1:0]          mode_q, mode_d;
  logic                rd_cmd_q, rd_cmd_d;
  logic                armed_q, armed_d;
  logic                miso_q, miso_d;
  logic                spi_we;
  logic                active, shift_rise, last_rise, last_fall;
  logic [7:0]          mem_q [DEPTH];
  logic                unused_msb;

  // Page mode keeps the bits above the page offset; SEQ and 2'b11 wrap over the whole array.
  function automatic logic [AW-1:0] adv(input logic [AW-1:0] a, input logic [1:0] m);
    logic [AW-1:0] inc;
    inc = a + 1'b1;
    if (m == MODE_PAGE) return (a & ~PAGE_MASK) | (inc & PAGE_MASK);
    return inc;
  endfunction

  assign active     = armed_q & ~ce_s;
  assign shift_rise = active & sck_rise &
                      (state_q inside {ST_CMD, ST_ADDR, ST_WR, ST_MODE_WR});
  assign last_rise  = (state_q == ST_ADDR) ? (bit_cnt_q == CW'(ADDR_W - 1))
                                           : (bit_cnt_q == CW'(7));
  assign last_fall  = (bit_cnt_q == CW'(7));
  assign unused_msb = in_sh_q[ADDR_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CMD;
      bit_cnt_q <= '0;
      in_sh_q   <= '0;
      out_sh_q  <= '0;
      addr_q    <= '0;
      mode_q    <= MODE_SEQ;
      rd_cmd_q  <= 1'b0;
      armed_q   <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      in_sh_q   <= in_sh_d;
      out_sh_q  <= out_sh_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      rd_cmd_q  <= rd_cmd_d;
      armed_q   <= armed_d;
      miso_q    <= miso_d;
    end
  end

  // Single write port: an SPI commit takes priority over the backdoor.
  always_ff @(posedge clk) begin
    if (spi_we) mem_q[addr_q] <= in_sh_d[7:0];
    else if (load_en) mem_q[load_addr] <= load_data;
  end

  always_comb begin
    state_d = state_q;
    if (!active) begin
      state_d = ST_CMD;
    end else if (shift_rise && last_rise) begin
      case (state_q)
        ST_CMD: begin
          case (in_sh_d[7:0])
            CMD_READ, CMD_WRITE: state_d = ST_ADDR;
            CMD_RDMR:            state_d = ST_MODE_RD;
            CMD_WRMR:            state_d = ST_MODE_WR;
            default:             state_d = ST_IGNORE;
          endcase
        end
        ST_ADDR:    state_d = rd_cmd_q ? ST_RD : ST_WR;
        ST_WR:      if (mode_q == MODE_BYTE) state_d = ST_IGNORE;
        ST_MODE_WR: state_d = ST_IGNORE;
        default:    state_d = state_q;
      endcase
    end else if (sck_fall && state_q == ST_RD && last_fall && mode_q == MODE_BYTE) begin
      state_d = ST_IGNORE;
    end
  end

  always_comb begin
    in_sh_d   = in_sh_q;
    out_sh_d  = out_sh_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    rd_cmd_d  = rd_cmd_q;
    miso_d    = miso_q;
    spi_we    = 1'b0;
    armed_d   = armed_q | ce_s;
    if (!active) begin
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else if (shift_rise) begin
      in_sh_d   = {in_sh_q[ADDR_W-2:0], mosi_s};
      bit_cnt_d = last_rise ? '0 : bit_cnt_q + 1'b1;
      if (last_rise) begin
        case (state_q)
          ST_CMD: begin
            rd_cmd_d = (in_sh_d[7:0] == CMD_READ);
            out_sh_d = {mode_q, 6'b0};
          end
          // The first read byte is staged here so its MSB leaves on the very next fall.
          ST_ADDR: begin
            addr_d   = in_sh_d[AW-1:0];
            out_sh_d = mem_q[in_sh_d[AW-1:0]];
          end
          ST_WR: begin
            spi_we = 1'b1;
            addr_d = adv(addr_q, mode_q);
          end
          ST_MODE_WR: mode_d = in_sh_d[7:6];
          default: ;
        endcase
      end
    end else if (sck_fall) begin
      if (state_q == ST_RD || state_q == ST_MODE_RD) begin
        miso_d    = out_sh_q[7];
        out_sh_d  = {out_sh_q[6:0], 1'b0};
        bit_cnt_d = last_fall ? '0 : bit_cnt_q + 1'b1;
        if (last_fall) begin
          if (state_q == ST_RD) begin
            addr_d   = adv(addr_q, mode_q);
            out_sh_d = mem_q[adv(addr_q, mode_q)];
          end else begin
            out_sh_d = {mode_q, 6'b0};
          end
        end
      end else begin
        miso_d = 1'b0;
      end
    end
  end

  always_comb begin
    spi_miso    = miso_q;
    busy        = active;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_spi_sram_model.sv
// Self-checking bench for spi_sram_model: bit-banged SPI master, table of read vectors, corner sequences.
module tb_spi_sram_model;
  import spi_mem_pkg::*;

  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b0;
  logic       spi_ce = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = 8'h00;
  logic [7:0] load_data = 8'h00;
  logic       spi_miso;
  logic       busy;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_sram_model dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_clk     (spi_clk),
    .spi_ce      (spi_ce),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    string       name;
    bit          set_mode;
    logic [7:0]  mode;
    logic [7:0]  cmd;
    bit          has_addr;
    logic [23:0] addr;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input string name, input bit set_mode, input logic [7:0] mode,
                              input logic [7:0] cmd, input bit has_addr, input logic [23:0] addr,
                              input int n, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.set_mode = set_mode; v.mode = mode; v.cmd = cmd;
    v.has_addr = has_addr; v.addr = addr; v.n = n; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Master samples MISO just before each rising edge, MSB first.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (H) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_clk = 1'b1;
      repeat (H) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    @(negedge clk);
    spi_ce = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (H) @(negedge clk);
    spi_ce = 1'b1;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input bit has_addr, input logic [23:0] addr);
    logic [7:0] rx;
    spi_bits(cmd, 8, rx);
    if (has_addr)
      for (int b = 2; b >= 0; b--) spi_bits(addr[8*b +: 8], 8, rx);
  endtask

  task automatic read_txn(input string name, input logic [7:0] cmd, input bit has_addr,
                          input logic [23:0] addr, input int n, input bit chk_busy);
    logic [7:0] rx, exp;
    spi_begin();
    send_hdr(cmd, has_addr, addr);
    for (int k = 0; k < n; k++) begin
      spi_bits(8'h00, 8, rx);
      if (chk_busy) check($sformatf("%s busy%0d", name, k), busy, 1);
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL %s byte%0d: got %0h expected nothing queued", name, k, rx);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("%s byte%0d", name, k), rx, exp);
      end
    end
    spi_end();
  endtask

  task automatic write_txn(input logic [23:0] addr, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] rx;
    spi_begin();
    send_hdr(CMD_WRITE, 1, addr);
    spi_bits(d0, 8, rx);
    spi_bits(d1, 8, rx);
    spi_end();
  endtask

  task automatic wrmr(input logic [7:0] mode);
    logic [7:0] rx;
    spi_begin();
    send_hdr(CMD_WRMR, 0, 24'h0);
    spi_bits(mode, 8, rx);
    spi_end();
  endtask

  initial begin
    logic [7:0] boot [12];
    logic [7:0] rx;
    boot = '{8'h3E, 8'h03, 8'h26, 8'hFF, 8'h2E, 8'h00, 8'h3D, 8'h00, 8'hC2, 8'h06, 8'h00, 8'h00};

    vecs[0] = mk("seq rd 10",   0, 8'h00, 8'h03, 1, 24'h000010, 3, 32'hAA559900);
    vecs[1] = mk("seq wrap ff", 0, 8'h00, 8'h03, 1, 24'h0000FF, 2, 32'h5A3E0000);
    vecs[2] = mk("addr alias",  0, 8'h00, 8'h03, 1, 24'h123402, 1, 32'h26000000);
    vecs[3] = mk("page wrap",   1, 8'h80, 8'h03, 1, 24'h00001F, 2, 32'h773E0000);
    vecs[4] = mk("rdmr page",   0, 8'h00, 8'h05, 0, 24'h000000, 2, 32'h80800000);
    vecs[5] = mk("byte mode",   1, 8'h00, 8'h03, 1, 24'h000004, 2, 32'h2E000000);
    vecs[6] = mk("unknown 9f",  0, 8'h00, 8'h9F, 0, 24'h000000, 2, 32'h00000000);
    vecs[7] = mk("rdmr byte",   0, 8'h00, 8'h05, 0, 24'h000000, 1, 32'h00000000);
    vecs[8] = mk("seq again",   1, 8'h40, 8'h03, 1, 24'h000008, 2, 32'hC2060000);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset miso", spi_miso, 0);
    check("reset busy", busy, 0);
    check("reset state", dbg_state, ST_CMD);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 12; i++) preload(8'(i), boot[i]);
    preload(8'h12, 8'h99);
    preload(8'hFF, 8'h5A);
    preload(8'h1F, 8'h77);

    // Boot image readback with busy held high
    for (int i = 0; i < 12; i++) exp_q.push_back(boot[i]);
    read_txn("boot read", CMD_READ, 1, 24'h000000, 12, 1);
    check("busy idle", busy, 0);

    exp_q.push_back(8'h40);
    read_txn("rdmr reset", CMD_RDMR, 0, 24'h0, 1, 0);

    write_txn(24'h000010, 8'hAA, 8'h55);

    foreach (vecs[i]) begin
      if (vecs[i].set_mode) wrmr(vecs[i].mode);
      for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].exp[31-8*k -: 8]);
      read_txn(vecs[i].name, vecs[i].cmd, vecs[i].has_addr, vecs[i].addr, vecs[i].n, 0);
    end

    // Page-mode write wraps inside its page
    wrmr(8'h80);
    write_txn(24'h00003F, 8'h11, 8'h22);
    wrmr(8'h40);
    exp_q.push_back(8'h11);
    read_txn("page wr 3f", CMD_READ, 1, 24'h00003F, 1, 0);
    exp_q.push_back(8'h22);
    read_txn("page wr 20", CMD_READ, 1, 24'h000020, 1, 0);

    // Partial write byte is discarded when CE rises
    spi_begin();
    send_hdr(CMD_WRITE, 1, 24'h000000);
    spi_bits(8'hFF, 5, rx);
    spi_end();
    check("partial miso", spi_miso, 0);
    check("partial state", dbg_state, ST_CMD);
    exp_q.push_back(8'h3E);
    read_txn("partial wr", CMD_READ, 1, 24'h000000, 1, 0);

    // Reset in the middle of a page-mode read
    wrmr(8'h80);
    spi_begin();
    send_hdr(CMD_READ, 1, 24'h000000);
    spi_bits(8'h00, 8, rx);
    check("pre-reset byte", rx, 8'h3E);
    spi_bits(8'h00, 3, rx);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst miso", spi_miso, 0);
    check("midrst state", dbg_state, ST_CMD);
    check("midrst busy", busy, 0);
    rst_n = 1'b1;
    repeat (2*H) @(negedge clk);
    spi_ce = 1'b1;
    repeat (2*H) @(negedge clk);
    exp_q.push_back(8'h40);
    read_txn("rdmr after rst", CMD_RDMR, 0, 24'h0, 1, 0);
    exp_q.push_back(8'h3E);
    read_txn("read after rst", CMD_READ, 1, 24'h000000, 1, 0);

    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL leftover: got %0d queued bytes expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
